// File: rtl/difftest_commit_queue_if.sv
// rtl/difftest_commit_queue_if.sv - commit-lane capture and drain bundle for difftest_commit_queue
interface difftest_commit_queue_if #(
  parameter int NCOMMIT = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16
);
  logic [NCOMMIT-1:0]         in_valid;
  logic [NCOMMIT*XLEN-1:0]    in_pc;
  logic [NCOMMIT*32-1:0]      in_inst;
  logic [NCOMMIT-1:0]         in_wen;
  logic [NCOMMIT*5-1:0]       in_waddr;
  logic [NCOMMIT*XLEN-1:0]    in_wdata;
  logic                       stall_req;
  logic                       deq_valid;
  logic                       deq_ready;
  logic [XLEN-1:0]            deq_pc;
  logic [31:0]                deq_inst;
  logic                       deq_wen;
  logic [4:0]                 deq_waddr;
  logic [XLEN-1:0]            deq_wdata;
  logic [31:0]                deq_seq;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;
  logic                       hang;
  logic [63:0]                commit_cnt;

  modport master (
    output in_valid, in_pc, in_inst, in_wen, in_waddr, in_wdata, deq_ready,
    input  stall_req, deq_valid, deq_pc, deq_inst, deq_wen, deq_waddr, deq_wdata, deq_seq,
           count, overflow, hang, commit_cnt
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_wen, in_waddr, in_wdata, deq_ready,
    output stall_req, deq_valid, deq_pc, deq_inst, deq_wen, deq_waddr, deq_wdata, deq_seq,
           count, overflow, hang, commit_cnt
  );
endinterface

// File: rtl/difftest_commit_queue.sv
// rtl/difftest_commit_queue.sv - multi-lane commit trace FIFO with seq tagging, overflow and hang watchdog
module difftest_commit_queue #(
  parameter int NCOMMIT = 2,
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 4096
) (
  input logic                   clock,
  input logic                   reset,
  difftest_commit_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     inst_mem  [DEPTH];
  logic            wen_mem   [DEPTH];
  logic [4:0]      waddr_mem [DEPTH];
  logic [XLEN-1:0] wdata_mem [DEPTH];
  logic [31:0]     seq_mem   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d, hang_q, hang_d;
  logic [63:0]   cc_q, cc_d;
  logic [31:0]   seq_q, seq_d;
  logic [TW-1:0] wd_q, wd_d;

  logic [CW-1:0] free, n;
  logic          pop;
  logic          lane_acc  [NCOMMIT];
  logic [AW-1:0] lane_slot [NCOMMIT];
  logic [31:0]   lane_seq  [NCOMMIT];

  always_comb begin
    free       = CW'(DEPTH) - count_q;
    n          = '0;
    overflow_d = overflow_q;
    // n doubles as the running rank, so accepted lanes pack into consecutive slots
    for (int i = 0; i < NCOMMIT; i++) begin
      lane_acc[i]  = 1'b0;
      lane_slot[i] = wr_ptr_q + AW'(n);
      lane_seq[i]  = seq_q + 32'(n);
      if (bus.in_valid[i]) begin
        if (n < free) begin
          lane_acc[i] = 1'b1;
          n           = n + CW'(1);
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
    pop      = (count_q != '0) && bus.deq_ready;
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(n);
    count_d  = count_q + n - CW'(pop);
    seq_d    = seq_q + 32'(n);
    cc_d     = cc_q + 64'(n);
    if (n != '0)
      wd_d = '0;
    else if (wd_q != TW'(TIMEOUT))
      wd_d = wd_q + TW'(1);
    else
      wd_d = wd_q;
    hang_d = hang_q | ((TIMEOUT != 0) && (wd_d == TW'(TIMEOUT)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      hang_q     <= 1'b0;
      cc_q       <= '0;
      seq_q      <= '0;
      wd_q       <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      hang_q     <= hang_d;
      cc_q       <= cc_d;
      seq_q      <= seq_d;
      wd_q       <= wd_d;
    end
  end

  // Storage is intentionally not reset; deq data is only meaningful while deq_valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NCOMMIT; i++) begin
      if (lane_acc[i]) begin
        pc_mem[lane_slot[i]]    <= bus.in_pc[i*XLEN +: XLEN];
        inst_mem[lane_slot[i]]  <= bus.in_inst[i*32 +: 32];
        wen_mem[lane_slot[i]]   <= bus.in_wen[i];
        waddr_mem[lane_slot[i]] <= bus.in_waddr[i*5 +: 5];
        wdata_mem[lane_slot[i]] <= bus.in_wdata[i*XLEN +: XLEN];
        seq_mem[lane_slot[i]]   <= lane_seq[i];
      end
    end
  end

  assign bus.deq_valid  = (count_q != '0);
  assign bus.deq_pc     = pc_mem[rd_ptr_q];
  assign bus.deq_inst   = inst_mem[rd_ptr_q];
  assign bus.deq_wen    = wen_mem[rd_ptr_q];
  assign bus.deq_waddr  = waddr_mem[rd_ptr_q];
  assign bus.deq_wdata  = wdata_mem[rd_ptr_q];
  assign bus.deq_seq    = seq_mem[rd_ptr_q];
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.hang       = hang_q;
  assign bus.commit_cnt = cc_q;
  assign bus.stall_req  = (CW'(DEPTH) - count_q) < CW'(NCOMMIT);
endmodule

// File: tb/tb_difftest_commit_queue.sv
// tb/tb_difftest_commit_queue.sv - vector, directed and randomized checks of difftest_commit_queue
module tb_difftest_commit_queue;
  localparam int NC = 2;
  localparam int DP = 16;
  localparam int TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  difftest_commit_queue_if #(.NCOMMIT(NC), .XLEN(32), .DEPTH(DP)) bus ();

  difftest_commit_queue #(.NCOMMIT(NC), .DEPTH(DP), .XLEN(32), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc, inst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata, seq;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_cc;
  logic [31:0] m_seq;
  int          m_idle;
  bit          m_ovf, m_hang;

  typedef struct {
    bit          rst;
    bit [1:0]    v;
    logic [31:0] pc0, pc1;
    bit          rdy;
    int          e_count;
    bit          e_dv;
    logic [31:0] e_pc, e_seq;
    bit          e_stall, e_ovf;
    int          e_cc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit [1:0] v, input bit rdy,
                              input ent_t lane [NC]);
    int free, n;
    if (rst) begin
      mq.delete();
      m_cc = 0; m_seq = 0; m_idle = 0; m_ovf = 0; m_hang = 0;
      return;
    end
    free = DP - mq.size();
    if (mq.size() != 0 && rdy) void'(mq.pop_front());
    n = 0;
    for (int i = 0; i < NC; i++) begin
      if (v[i]) begin
        if (n < free) begin
          ent_t e;
          e = lane[i];
          e.seq = m_seq + n;
          mq.push_back(e);
          n++;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_seq += n;
    m_cc  += n;
    if (n > 0) m_idle = 0;
    else if (m_idle < TO) m_idle++;
    if (m_idle >= TO) m_hang = 1;
  endtask

  task automatic check_model();
    chk("m_count", 64'(bus.count), 64'(mq.size()));
    chk("m_deq_valid", 64'(bus.deq_valid), 64'(mq.size() != 0));
    chk("m_stall", 64'(bus.stall_req), 64'((DP - mq.size()) < NC));
    chk("m_overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("m_hang", 64'(bus.hang), 64'(m_hang));
    chk("m_commit_cnt", bus.commit_cnt, m_cc);
    if (mq.size() != 0) begin
      chk("m_deq_pc", 64'(bus.deq_pc), 64'(mq[0].pc));
      chk("m_deq_inst", 64'(bus.deq_inst), 64'(mq[0].inst));
      chk("m_deq_wen", 64'(bus.deq_wen), 64'(mq[0].wen));
      chk("m_deq_waddr", 64'(bus.deq_waddr), 64'(mq[0].waddr));
      chk("m_deq_wdata", 64'(bus.deq_wdata), 64'(mq[0].wdata));
      chk("m_deq_seq", 64'(bus.deq_seq), 64'(mq[0].seq));
    end
  endtask

  task automatic step(input bit rst, input bit [1:0] v, input logic [31:0] pc0,
                      input logic [31:0] pc1, input bit rdy);
    ent_t lane [NC];
    lane[0].pc = pc0;
    lane[1].pc = pc1;
    for (int i = 0; i < NC; i++) begin
      lane[i].inst  = $urandom;
      lane[i].wen   = 1'($urandom_range(0, 1));
      lane[i].waddr = 5'($urandom_range(0, 31));
      lane[i].wdata = $urandom;
      lane[i].seq   = 0;
      bus.in_pc[i*32 +: 32]    = lane[i].pc;
      bus.in_inst[i*32 +: 32]  = lane[i].inst;
      bus.in_wen[i]            = lane[i].wen;
      bus.in_waddr[i*5 +: 5]   = lane[i].waddr;
      bus.in_wdata[i*32 +: 32] = lane[i].wdata;
    end
    reset         = rst;
    bus.in_valid  = v;
    bus.deq_ready = rdy;
    model_update(rst, v, rdy, lane);
    @(posedge clock);
    #1;
    check_model();
  endtask

  initial begin
    bus.in_valid = '0; bus.in_pc = '0; bus.in_inst = '0; bus.in_wen = '0;
    bus.in_waddr = '0; bus.in_wdata = '0; bus.deq_ready = 1'b0;

    vecs[0] = '{1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0};
    vecs[1] = '{0, 2'b11, 32'h8000_0000, 32'h8000_0004, 0, 2, 1, 32'h8000_0000, 0, 0, 0, 2};
    vecs[2] = '{0, 2'b00, 32'h0, 32'h0, 1, 1, 1, 32'h8000_0004, 1, 0, 0, 2};
    vecs[3] = '{0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 2};
    vecs[4] = '{1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0};
    vecs[5] = '{0, 2'b10, 32'hdead, 32'h100, 0, 1, 1, 32'h100, 0, 0, 0, 1};
    vecs[6] = '{0, 2'b00, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 1};

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].pc0, vecs[i].pc1, vecs[i].rdy);
      chk("vec_count", 64'(bus.count), 64'(vecs[i].e_count));
      chk("vec_deq_valid", 64'(bus.deq_valid), 64'(vecs[i].e_dv));
      if (vecs[i].e_dv) begin
        chk("vec_deq_pc", 64'(bus.deq_pc), 64'(vecs[i].e_pc));
        chk("vec_deq_seq", 64'(bus.deq_seq), 64'(vecs[i].e_seq));
      end
      chk("vec_stall", 64'(bus.stall_req), 64'(vecs[i].e_stall));
      chk("vec_overflow", 64'(bus.overflow), 64'(vecs[i].e_ovf));
      chk("vec_commit_cnt", bus.commit_cnt, 64'(vecs[i].e_cc));
    end

    // watchdog fires after exactly TIMEOUT idle cycles
    step(1, 2'b00, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 2'b00, 0, 0, 0);
      chk("idle_hang", 64'(bus.hang), 64'(k >= TO));
    end
    chk("idle_count", 64'(bus.count), 64'd0);
    chk("idle_deq_valid", 64'(bus.deq_valid), 64'd0);
    chk("idle_stall", 64'(bus.stall_req), 64'd0);

    // fill to full, then a full cycle drops both lanes
    step(1, 2'b00, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 2'b11, $urandom, $urandom, 0);
      chk("fill_count", 64'(bus.count), 64'(2 * k));
      chk("fill_stall", 64'(bus.stall_req), 64'(k == 8));
    end
    step(0, 2'b11, $urandom, $urandom, 0);
    chk("full_count", 64'(bus.count), 64'd16);
    chk("full_overflow", 64'(bus.overflow), 64'd1);

    // one free slot plus a same-cycle pop: only lane 0 fits
    step(1, 2'b00, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 2'b11, $urandom, $urandom, 0);
    step(0, 2'b01, $urandom, $urandom, 0);
    chk("c15_count", 64'(bus.count), 64'd15);
    chk("c15_stall", 64'(bus.stall_req), 64'd1);
    chk("c15_overflow_before", 64'(bus.overflow), 64'd0);
    step(0, 2'b11, $urandom, $urandom, 1);
    chk("c15_count_after", 64'(bus.count), 64'd15);
    chk("c15_overflow", 64'(bus.overflow), 64'd1);
    chk("c15_head_seq", 64'(bus.deq_seq), 64'd1);
    chk("c15_commit_cnt", bus.commit_cnt, 64'd16);

    // mid-operation reset discards contents and sticky flags
    step(1, 2'b00, 0, 0, 0);
    step(0, 2'b11, $urandom, $urandom, 0);
    step(0, 2'b11, $urandom, $urandom, 0);
    step(0, 2'b01, $urandom, $urandom, 0);
    chk("rst_fill_count", 64'(bus.count), 64'd5);
    for (int k = 0; k < TO; k++) step(0, 2'b00, 0, 0, 0);
    chk("rst_pre_hang", 64'(bus.hang), 64'd1);
    step(1, 2'b00, 0, 0, 0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    chk("rst_hang", 64'(bus.hang), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    step(0, 2'b01, 32'h4000, 32'h0, 0);
    chk("rst_next_seq", 64'(bus.deq_seq), 64'd0);
    chk("rst_next_pc", 64'(bus.deq_pc), 64'h4000);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
           $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
